// File: rtl/bp_lce_hybrid_resp_tx.sv
// bp_lce_hybrid_resp_tx: LCE response transmitter emitting one BedRock header plus data beats for dirty writebacks
// clk_i/reset_i: clock, synchronous active-high reset
// lce_id_i: this LCE's id, sent as payload src_id
// req_*: one-at-a-time response request from the command handler, consumed by req_yumi_o
// lce_resp_header_*: burst header channel (valid/ready), lce_resp_has_data_o marks a data-carrying burst
// lce_resp_data_*: data beat channel (valid/ready), lce_resp_last_o marks the final beat
// busy_o: a response is in flight
// Header layout, LSB first: msg_type[4], subop[4], addr, size[3], way_id, src_id, dst_id
module bp_lce_hybrid_resp_tx #(
    parameter int paddr_width_p = 40,
    parameter int lce_id_width_p = 4,
    parameter int cce_id_width_p = 4,
    parameter int lce_assoc_p = 8,
    parameter int cce_block_width_p = 512,
    parameter int lce_data_width_p = 64,
    localparam int msg_type_width_lp = 4,
    localparam int beats_lp = cce_block_width_p / lce_data_width_p,
    localparam int cnt_width_lp = beats_lp > 1 ? $clog2(beats_lp) : 1,
    localparam int way_width_lp = lce_assoc_p > 1 ? $clog2(lce_assoc_p) : 1,
    localparam int lce_resp_msg_header_width_lp = msg_type_width_lp + 4 + paddr_width_p + 3
        + way_width_lp + lce_id_width_p + cce_id_width_p
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic [lce_id_width_p-1:0]               lce_id_i,
    input  logic                                    req_v_i,
    output logic                                    req_yumi_o,
    input  logic [msg_type_width_lp-1:0]            req_msg_type_i,
    input  logic [paddr_width_p-1:0]                req_addr_i,
    input  logic [cce_id_width_p-1:0]               req_dst_id_i,
    input  logic                                    req_dirty_i,
    input  logic [cce_block_width_p-1:0]            req_data_i,
    output logic [lce_resp_msg_header_width_lp-1:0] lce_resp_header_o,
    output logic                                    lce_resp_header_v_o,
    input  logic                                    lce_resp_header_ready_and_i,
    output logic                                    lce_resp_has_data_o,
    output logic [lce_data_width_p-1:0]             lce_resp_data_o,
    output logic                                    lce_resp_data_v_o,
    input  logic                                    lce_resp_data_ready_and_i,
    output logic                                    lce_resp_last_o,
    output logic                                    busy_o
);
    localparam int offset_lp = $clog2(cce_block_width_p / 8);
    localparam logic [msg_type_width_lp-1:0] e_wb = 4'd3;
    localparam logic [msg_type_width_lp-1:0] e_null_wb = 4'd4;
    localparam logic [2:0] size_block_lp = 3'(offset_lp);
    localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(beats_lp - 1);

    typedef enum logic [1:0] {e_ready, e_header, e_data} state_e;

    state_e                            state_r, state_n;
    logic [cnt_width_lp-1:0]           cnt_r, cnt_n;
    logic [msg_type_width_lp-1:0]      type_r;
    logic [paddr_width_p-1:0]          addr_r;
    logic [cce_id_width_p-1:0]         dst_r;
    logic                              dirty_r;
    logic [cce_block_width_p-1:0]      block_r;
    logic [lce_id_width_p-1:0]         lce_id_r;
    logic [beats_lp-1:0][lce_data_width_p-1:0] beats;
    logic                              dirty_wb, wb_like, last;
    logic [msg_type_width_lp-1:0]      out_type;
    logic [paddr_width_p-1:0]          out_addr;

    assign beats    = block_r;
    assign dirty_wb = type_r == e_wb && dirty_r;
    assign wb_like  = type_r == e_wb || type_r == e_null_wb;
    assign out_type = type_r == e_wb && !dirty_r ? e_null_wb : type_r;
    assign out_addr = wb_like ? {addr_r[paddr_width_p-1:offset_lp], offset_lp'(0)} : addr_r;
    assign last     = cnt_r == last_cnt_lp;

    assign lce_resp_header_o = {dst_r, lce_id_r, way_width_lp'(0), dirty_wb ? size_block_lp : 3'd0,
                                out_addr, 4'd0, out_type};
    assign lce_resp_has_data_o = dirty_wb && state_r != e_ready;
    assign lce_resp_data_o = beats[cnt_r];
    assign lce_resp_last_o = lce_resp_data_v_o && last;
    assign busy_o = state_r != e_ready;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_ready;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
        if (req_yumi_o) begin
            type_r   <= req_msg_type_i;
            addr_r   <= req_addr_i;
            dst_r    <= req_dst_id_i;
            dirty_r  <= req_dirty_i;
            block_r  <= req_data_i;
            lce_id_r <= lce_id_i;
        end
    end

    always_comb begin
        state_n = state_r;
        cnt_n = cnt_r;
        req_yumi_o = 1'b0;
        lce_resp_header_v_o = 1'b0;
        lce_resp_data_v_o = 1'b0;
        case (state_r)
            e_ready: begin
                req_yumi_o = req_v_i && !reset_i;
                state_n = req_v_i ? e_header : e_ready;
            end
            e_header: begin
                lce_resp_header_v_o = 1'b1;
                cnt_n = '0;
                state_n = !lce_resp_header_ready_and_i ? e_header : dirty_wb ? e_data : e_ready;
            end
            e_data: begin
                lce_resp_data_v_o = 1'b1;
                cnt_n = !lce_resp_data_ready_and_i ? cnt_r : last ? '0 : cnt_r + 1'b1;
                state_n = lce_resp_data_ready_and_i && last ? e_ready : e_data;
            end
            default: state_n = e_ready;
        endcase
    end
endmodule

// File: tb/tb_bp_lce_hybrid_resp_tx.sv
// tb_bp_lce_hybrid_resp_tx: scoreboard bench for the LCE response transmitter
module tb_bp_lce_hybrid_resp_tx;
    localparam int PA = 40, BLK = 512, DW = 64, NB = BLK / DW, HW = 62;
    localparam logic [3:0] SYNC = 4'd0, INV = 4'd1, COH = 4'd2, WB = 4'd3, NULL_WB = 4'd4;

    logic clk = 0, reset_i = 1;
    logic [3:0] lce_id_i = 0;
    logic req_v_i = 0, req_yumi_o;
    logic [3:0] req_msg_type_i = 0;
    logic [PA-1:0] req_addr_i = 0;
    logic [3:0] req_dst_id_i = 0;
    logic req_dirty_i = 0;
    logic [BLK-1:0] req_data_i = 0;
    logic [HW-1:0] header_o;
    logic header_v_o, has_data_o, data_v_o, last_o, busy_o;
    logic header_ready = 1, data_ready = 1;
    logic [DW-1:0] data_o;

    int total = 0, bad = 0;
    int hr_mode = 0, dr_mode = 0;
    logic [HW-1:0] hdr_q[$];
    bit hd_q[$];
    logic [DW-1:0] beat_q[$];
    bit idle, prev_hs, prev_ds, prev_hd, prev_last;
    logic [HW-1:0] prev_hdr;
    logic [DW-1:0] prev_data;

    bp_lce_hybrid_resp_tx dut (
        .clk_i(clk), .reset_i(reset_i), .lce_id_i(lce_id_i),
        .req_v_i(req_v_i), .req_yumi_o(req_yumi_o), .req_msg_type_i(req_msg_type_i),
        .req_addr_i(req_addr_i), .req_dst_id_i(req_dst_id_i), .req_dirty_i(req_dirty_i),
        .req_data_i(req_data_i),
        .lce_resp_header_o(header_o), .lce_resp_header_v_o(header_v_o),
        .lce_resp_header_ready_and_i(header_ready), .lce_resp_has_data_o(has_data_o),
        .lce_resp_data_o(data_o), .lce_resp_data_v_o(data_v_o),
        .lce_resp_data_ready_and_i(data_ready), .lce_resp_last_o(last_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial assert (BLK % DW == 0) else $fatal(1, "beat width does not divide block width");

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [HW-1:0] mk_hdr(input logic [3:0] t, input logic [PA-1:0] a,
                                             input logic [3:0] d, input logic dirty, input logic [3:0] id);
        logic [3:0] nt;
        logic [PA-1:0] na;
        logic [2:0] sz;
        nt = (t == WB && !dirty) ? NULL_WB : t;
        na = (nt == WB || nt == NULL_WB) ? a - a % (BLK / 8) : a;
        sz = (t == WB && dirty) ? 3'($clog2(BLK / 8)) : 3'd0;
        return {d, id, 3'd0, sz, na, 4'd0, nt};
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        header_ready = hr_mode == 0 ? 1'b1 : hr_mode == 1 ? 1'($urandom % 2) : 1'b0;
        data_ready = dr_mode == 0 ? 1'b1 : dr_mode == 1 ? 1'($urandom % 2) : ~data_ready;
    end

    always @(posedge clk) if (reset_i) begin
        hdr_q.delete();
        hd_q.delete();
        beat_q.delete();
        prev_hs = 0;
        prev_ds = 0;
    end

    always @(negedge clk) if (!reset_i) begin
        idle = hdr_q.size() == 0 && beat_q.size() == 0;
        chk("busy", busy_o, !idle);
        chk("yumi", req_yumi_o, req_v_i && idle);
        chk("hdr_v", header_v_o, hdr_q.size() != 0);
        chk("data_v", data_v_o, hdr_q.size() == 0 && beat_q.size() != 0);
        if (!data_v_o) chk("last_idle", last_o, 0);
        if (idle) chk("has_data_idle", has_data_o, 0);
        if (prev_hs) begin
            chk("hdr_hold", header_o, prev_hdr);
            chk("has_data_hold", has_data_o, prev_hd);
        end
        if (prev_ds) begin
            chk("data_hold", data_o, prev_data);
            chk("last_hold", last_o, prev_last);
        end
        if (data_v_o && hdr_q.size() == 0 && beat_q.size() != 0) begin
            chk("data", data_o, beat_q[0]);
            chk("last", last_o, beat_q.size() == 1);
            if (data_ready) void'(beat_q.pop_front());
        end
        if (header_v_o && hdr_q.size() != 0) begin
            chk("hdr", header_o, hdr_q[0]);
            chk("has_data", has_data_o, hd_q[0]);
            if (header_ready) begin
                void'(hdr_q.pop_front());
                void'(hd_q.pop_front());
            end
        end
        prev_hs = header_v_o && !header_ready;
        prev_hdr = header_o;
        prev_hd = has_data_o;
        prev_ds = data_v_o && !data_ready;
        prev_data = data_o;
        prev_last = last_o;
        if (req_yumi_o) begin
            assert (req_msg_type_i <= WB) else $error("unsupported response type %0d", req_msg_type_i);
            hdr_q.push_back(mk_hdr(req_msg_type_i, req_addr_i, req_dst_id_i, req_dirty_i, lce_id_i));
            hd_q.push_back(req_msg_type_i == WB && req_dirty_i);
            if (req_msg_type_i == WB && req_dirty_i)
                for (int k = 0; k < NB; k++) beat_q.push_back(DW'(req_data_i >> (DW * k)));
        end
    end

    task automatic send(input logic [3:0] t, input logic [PA-1:0] a, input logic [3:0] d,
                        input logic dirty, input logic [BLK-1:0] blk, input bit hold);
        int n = 0;
        req_v_i = 1;
        req_msg_type_i = t;
        req_addr_i = a;
        req_dst_id_i = d;
        req_dirty_i = dirty;
        req_data_i = blk;
        lce_id_i = 4'($urandom);
        forever begin
            @(negedge clk);
            if (req_yumi_o) break;
            if (++n > 200) begin
                chk("yumi_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!hold) req_v_i = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((hdr_q.size() != 0 || beat_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("drain_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BLK-1:0] rand_blk();
        logic [BLK-1:0] b;
        for (int k = 0; k < BLK / 32; k++) b[k*32 +: 32] = $urandom;
        return b;
    endfunction

    initial begin
        logic [BLK-1:0] pat;
        for (int k = 0; k < NB; k++) pat[k*DW +: DW] = 64'h1111_1111_1111_1111 * k;
        repeat (3) @(posedge clk);
        #1;
        reset_i = 0;
        @(posedge clk);
        #1;
        send(SYNC, 40'h00_8000_0040, 4'd0, 1'b0, '0, 0);
        drain();
        hr_mode = 2;
        send(INV, 40'h00_8000_0080, 4'd2, 1'b0, '0, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        hr_mode = 0;
        drain();
        dr_mode = 2;
        send(WB, 40'h00_8000_0048, 4'd1, 1'b1, pat, 0);
        drain();
        dr_mode = 0;
        send(WB, 40'h00_8000_00c8, 4'd3, 1'b0, rand_blk(), 0);
        drain();
        send(COH, 40'h00_1234_5678, 4'd5, 1'b0, '0, 1);
        send(WB, 40'h00_0000_1f7f, 4'd6, 1'b1, rand_blk(), 0);
        drain();
        send(WB, 40'h00_8000_0100, 4'd7, 1'b1, pat, 0);
        repeat (5) @(negedge clk);
        reset_i = 1;
        @(posedge clk);
        #1;
        reset_i = 0;
        send(SYNC, 40'h00_8000_0040, 4'd4, 1'b0, '0, 0);
        drain();
        hr_mode = 1;
        dr_mode = 1;
        for (int i = 0; i < 40; i++)
            send(4'($urandom % 4), {8'($urandom), 32'($urandom)}, 4'($urandom), 1'($urandom % 2),
                 rand_blk(), i < 39 && $urandom % 2 == 1);
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
